// File: rtl/asteroids_input_mapper.sv
// Asteroids input mapper: turns hps_io PS/2 key events into held-key latches,
// merges joystick bits and stretches coin requests into fixed-width pulses
// with a post-pulse lockout. Drives the core's active-low BUTTON[7:0] bus
// from a register.
// Optional feature macro: ASTEROIDS_AUTOFIRE_EN (autofire square wave on fire).
// Output bit order: {right,left,start1,start2,fire,coin,thrust,shield}.
module asteroids_input_mapper #(
    parameter int COIN_PULSE      = 1250000,
    parameter int COIN_HOLDOFF    = 2500000,
    parameter int AUTOFIRE_PERIOD = 1562500
) (
    input  logic        clk_25,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joy,
    input  logic        autofire_on,
    output logic [7:0]  buttons_n,
    output logic        coin_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } coin_state_e;

    localparam logic [23:0] PULSE_LOAD = 24'(COIN_PULSE - 1);
    localparam logic [23:0] HOLD_LOAD  = 24'(COIN_HOLDOFF - 1);
    localparam logic [23:0] AF_LAST    = 24'(AUTOFIRE_PERIOD - 1);

    // Map {ext,scancode} to {hit, latch index}; latch index equals the
    // output bit position so no second translation table is needed.
    function automatic logic [3:0] key_map(input logic [8:0] key);
        logic [3:0] res;
        case (key)
            9'h023, 9'h174:         res = 4'b1_111; // right
            9'h01C, 9'h16B:         res = 4'b1_110; // left
            9'h005, 9'h016:         res = 4'b1_101; // start1
            9'h006, 9'h01E:         res = 4'b1_100; // start2
            9'h03A, 9'h014:         res = 4'b1_011; // fire
            9'h004, 9'h02E, 9'h036: res = 4'b1_010; // coin key
            9'h04B, 9'h011:         res = 4'b1_001; // thrust
            9'h042, 9'h029:         res = 4'b1_000; // shield
            default:                res = 4'b0_000;
        endcase
        return res;
    endfunction

    logic        armed_q;
    logic        old_tog_q;
    logic        event_s;
    logic [3:0]  key_hit_s;
    logic [7:0]  keys_q;
    logic [7:0]  keys_d;
    logic [7:0]  req_s;
    logic        coin_req_s;
    logic        coin_prev_q;
    logic        coin_edge_s;
    coin_state_e state_q;
    coin_state_e state_d;
    logic [23:0] cnt_q;
    logic [23:0] cnt_d;
    logic        coin_on_s;
    logic        busy_d;
    logic        coin_busy_q;
    logic        fire_s;
    logic [7:0]  buttons_d;
    logic [7:0]  buttons_q;

    // A key event is a change of the toggle bit, but only once armed so the
    // arbitrary toggle level present at reset release never decodes.
    assign event_s   = armed_q & (old_tog_q ^ ps2_key[10]);
    assign key_hit_s = key_map(ps2_key[8:0]);

    // Arming flag and toggle history
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            armed_q   <= 1'b0;
            old_tog_q <= 1'b0;
        end else begin
            armed_q   <= 1'b1;
            old_tog_q <= ps2_key[10];
        end
    end

    // Next key-latch state: matched latch follows the pressed flag
    always_comb begin
        keys_d = keys_q;
        if (event_s && key_hit_s[3]) begin
            keys_d[key_hit_s[2:0]] = ps2_key[9];
        end else begin
            keys_d = keys_q;
        end
    end

    // Held-key latches
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            keys_q <= 8'h00;
        end else begin
            keys_q <= keys_d;
        end
    end

    // Keyboard OR joystick per function; start2 has no joystick source and
    // hyperspace on the stick drives shield.
    assign req_s = keys_q | {joy[0], joy[1], joy[8], 1'b0,
                             joy[4], joy[7], joy[5], joy[6]};

    assign coin_req_s  = req_s[2];
    assign coin_edge_s = coin_req_s & ~coin_prev_q;

    // Coin request history for rising-edge detection
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            coin_prev_q <= 1'b0;
        end else begin
            coin_prev_q <= coin_req_s;
        end
    end

    // Coin FSM state and down-counter register
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 24'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Coin FSM next state: edges outside IDLE are dropped, never queued
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (coin_edge_s) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_LOAD;
                end else begin
                    state_d = IDLE;
                    cnt_d   = 24'd0;
                end
            end
            PULSE: begin
                if (cnt_q == 24'd0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d   = cnt_q - 24'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 24'd0) begin
                    state_d = IDLE;
                    cnt_d   = 24'd0;
                end else begin
                    cnt_d   = cnt_q - 24'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 24'd0;
            end
        endcase
    end

    // Coin FSM outputs: pulse decode and busy flag aligned with the state
    always_comb begin
        coin_on_s = (state_q == PULSE);
        busy_d    = (state_d != IDLE);
    end

`ifdef ASTEROIDS_AUTOFIRE_EN
    logic [23:0] af_cnt_q;
    logic        af_phase_q;

    // Free-running autofire timebase; phase starts high so a press fires at once
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            af_cnt_q   <= 24'd0;
            af_phase_q <= 1'b1;
        end else if (af_cnt_q == AF_LAST) begin
            af_cnt_q   <= 24'd0;
            af_phase_q <= ~af_phase_q;
        end else begin
            af_cnt_q   <= af_cnt_q + 24'd1;
            af_phase_q <= af_phase_q;
        end
    end

    assign fire_s = req_s[3] & (autofire_on ? af_phase_q : 1'b1);

    logic unused_s;
    assign unused_s = ^{joy[15:9], joy[3:2]};
`else
    assign fire_s = req_s[3];

    // Pins that carry no function in this build are folded into one sink
    logic unused_s;
    assign unused_s = ^{joy[15:9], joy[3:2], autofire_on, AF_LAST};
`endif

    // Active-low button vector assembled from the merged requests
    always_comb begin
        buttons_d = ~{req_s[7], req_s[6], req_s[5], req_s[4],
                      fire_s, coin_on_s, req_s[1], req_s[0]};
    end

    // Output register straight into the core's BUTTON bus
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            buttons_q   <= 8'hFF;
            coin_busy_q <= 1'b0;
        end else begin
            buttons_q   <= buttons_d;
            coin_busy_q <= busy_d;
        end
    end

    assign buttons_n = buttons_q;
    assign coin_busy = coin_busy_q;

endmodule

// File: tb/tb_asteroids_input_mapper.sv
// Scoreboard bench for asteroids_input_mapper: the driver predicts every
// cycle's outputs from a timeline model and queues them; the monitor pops one
// expectation per clock and compares.
module tb_asteroids_input_mapper;

    localparam int CP = 4;
    localparam int CH = 8;
    localparam int AP = 3;
    localparam int NKEYS = 17;

    localparam logic [8:0] KCODE [NKEYS] = '{
        9'h023, 9'h174, 9'h01C, 9'h16B, 9'h005, 9'h016, 9'h006, 9'h01E,
        9'h03A, 9'h014, 9'h04B, 9'h011, 9'h042, 9'h029, 9'h004, 9'h02E, 9'h036};
    // button position for each code: 7 right .. 0 shield, 2 coin
    localparam int KBIT [NKEYS] = '{7, 7, 6, 6, 5, 5, 4, 4, 3, 3, 1, 1, 0, 0, 2, 2, 2};

    typedef struct {
        logic [7:0] btn;
        logic       busy;
    } exp_t;

    logic        clk_25 = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] ps2_key = 11'd0;
    logic [15:0] joy = 16'd0;
    logic        autofire_on = 1'b0;
    logic [7:0]  buttons_n;
    logic        coin_busy;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b0;

    // model state
    int         n;
    logic [7:0] keys;
    logic       prev_tog;
    logic       prev_coin;
    int         start;
    int         idle_from;

    asteroids_input_mapper #(
        .COIN_PULSE(CP),
        .COIN_HOLDOFF(CH),
        .AUTOFIRE_PERIOD(AP)
    ) dut (
        .clk_25(clk_25),
        .reset(reset),
        .ps2_key(ps2_key),
        .joy(joy),
        .autofire_on(autofire_on),
        .buttons_n(buttons_n),
        .coin_busy(coin_busy)
    );

    always #5 clk_25 = ~clk_25;

    function automatic int lookup(input logic [8:0] k);
        for (int i = 0; i < NKEYS; i++) begin
            if (KCODE[i] == k) return KBIT[i];
        end
        return -1;
    endfunction

`ifdef ASTEROIDS_AUTOFIRE_EN
    // autofire level in effect after the j-th post-reset clock edge
    function automatic logic af_level(input int j);
        return ((((j + 1) / AP) % 2) == 0);
    endfunction
`endif

    task automatic model_reset();
        n         = 0;
        keys      = 8'h00;
        prev_tog  = 1'b0;
        prev_coin = 1'b0;
        start     = -1000;
        idle_from = 0;
    endtask

    // Predict outputs after the coming edge from the inputs now applied
    task automatic step();
        exp_t e;
        logic [7:0] req;
        int b;
        req = keys;
        req[7] = req[7] | joy[0];
        req[6] = req[6] | joy[1];
        req[5] = req[5] | joy[8];
        req[3] = req[3] | joy[4];
        req[2] = req[2] | joy[7];
        req[1] = req[1] | joy[5];
        req[0] = req[0] | joy[6];
        if (req[2] && !prev_coin && n >= idle_from) begin
            start     = n;
            idle_from = n + CP + CH;
        end
        prev_coin = req[2];
`ifdef ASTEROIDS_AUTOFIRE_EN
        if (autofire_on && !af_level(n - 1)) req[3] = 1'b0;
`endif
        e.btn    = ~req;
        e.btn[2] = !((n - 1) >= start && (n - 1) <= start + CP - 1);
        e.busy   = (n >= start && n <= start + CP + CH - 1);
        if (n >= 1 && ps2_key[10] != prev_tog) begin
            b = lookup(ps2_key[8:0]);
            if (b >= 0) keys[b] = ps2_key[9];
        end
        prev_tog = ps2_key[10];
        exp_q.push_back(e);
        n++;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(negedge clk_25);
            step();
        end
    endtask

    task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
        @(negedge clk_25);
        ps2_key = {~ps2_key[10], pressed, ext, code};
        step();
    endtask

    task automatic pulse_coin();
        @(negedge clk_25);
        joy[7] = 1'b1;
        step();
        @(negedge clk_25);
        joy[7] = 1'b0;
        step();
    endtask

    task automatic do_reset(input logic tog, input bit chk);
        exp_t r;
        r.btn  = 8'hFF;
        r.busy = 1'b0;
        @(negedge clk_25);
        reset = 1'b1;
        ps2_key[10] = tog;
        if (chk) begin
            #1;
            vectors++;
            if (buttons_n !== 8'hFF || coin_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL async_reset buttons_n=%h coin_busy=%b, want ff 0", buttons_n, coin_busy);
            end
        end
        exp_q.push_back(r);
        mon_en = 1'b1;
        repeat (2) begin
            @(negedge clk_25);
            exp_q.push_back(r);
        end
        @(negedge clk_25);
        reset = 1'b0;
        model_reset();
        step();
    endtask

    task automatic rand_cycle();
        int idx;
        @(negedge clk_25);
        if ($urandom_range(0, 5) == 0) ps2_key[9:0] = 10'($urandom);
        if ($urandom_range(0, 3) == 0) begin
            ps2_key[10] = ~ps2_key[10];
            ps2_key[9]  = 1'($urandom);
            if ($urandom_range(0, 1) == 0) ps2_key[8:0] = KCODE[$urandom_range(0, NKEYS - 1)];
            else ps2_key[8:0] = 9'($urandom);
        end
        if ($urandom_range(0, 5) == 0) begin
            idx = $urandom_range(0, 15);
            joy[idx] = ~joy[idx];
        end
        if ($urandom_range(0, 40) == 0) autofire_on = ~autofire_on;
        step();
    endtask

    // Monitor: one expectation per clock, compared just after the edge
    always @(posedge clk_25) begin
        if (mon_en) begin
            #1;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL underflow at t=%0t: no expectation queued", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (buttons_n !== e.btn || coin_busy !== e.busy) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t buttons_n=%h coin_busy=%b, want %h %b",
                             $time, buttons_n, coin_busy, e.btn, e.busy);
                end
            end
        end
    end

    initial begin
        model_reset();
        // reset released with toggle high: no spurious event
        do_reset(1'b1, 1'b0);
        idle(5);
        // extended left arrow press and release
        send_key(1'b1, 1'b1, 8'h6B);
        idle(5);
        send_key(1'b0, 1'b1, 8'h6B);
        idle(5);
        // coin held for a long time: a single pulse
        @(negedge clk_25);
        joy[7] = 1'b1;
        step();
        idle(40);
        @(negedge clk_25);
        joy[7] = 1'b0;
        step();
        idle(3);
        // edge in holdoff is dropped, edge after idle gives a new pulse
        pulse_coin();
        idle(7);
        pulse_coin();
        idle(12);
        pulse_coin();
        idle(14);
        // two codes on the shield latch, then an unmapped code
        send_key(1'b1, 1'b0, 8'h29);
        idle(3);
        send_key(1'b0, 1'b0, 8'h42);
        idle(3);
        send_key(1'b1, 1'b0, 8'h55);
        idle(3);
        // fire held with autofire requested
        @(negedge clk_25);
        autofire_on = 1'b1;
        joy[4] = 1'b1;
        step();
        idle(12);
        @(negedge clk_25);
        joy[4] = 1'b0;
        autofire_on = 1'b0;
        step();
        // random traffic
        repeat (2000) rand_cycle();
        // reset in the middle of a coin pulse
        @(negedge clk_25);
        joy = 16'd0;
        step();
        idle(20);
        pulse_coin();
        idle(1);
        do_reset(1'b0, 1'b1);
        idle(5);
        repeat (500) rand_cycle();
        // drain the scoreboard
        @(posedge clk_25);
        #3;
        mon_en = 1'b0;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
